ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite responder that terminates the ahb_s side of the bus with a word-organised on-chip SRAM. It accepts pipelined address/data-phase transfers, inserts a configurable number of wait states, and performs byte, halfword and word reads and writes with little-endian byte lanes. It sits behind the bus decoder as a memory slave and serves as the target for the ahb_master UVM agent.

## Interface
- DEPTH, 1024: memory size in 32-bit words; power of two, minimum 4.
- WAIT_STATES, 0: wait cycles inserted in every OKAY data phase; range 0–15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; DEPTH*4-aligned.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 = byte, 001 = half, 010 = word.
- HBURST  in  3  ignored; each beat is handled independently.
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready; high means the previous data phase completes this cycle.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  00 = OKAY, 01 = ERROR.
- HRDATA  out  32  read data.

## Operation
- **Address-phase accept.** A transfer is accepted when HSEL && HREADY && HTRANS[1] are all high at a rising edge.
  - On accept, register addr_q (word index), lane_q[1:0], size_q and write_q.
  - IDLE and BUSY transfers, or HSEL low, produce a zero-wait OKAY and cause no memory access.
- **FSM states:** IDLE, DATA, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=OKAY. On an accepted transfer, go to DATA and load wcnt=WAIT_STATES. An illegal transfer goes to ERR1 instead (Configuration only).
  - DATA: HREADYOUT = (wcnt==0). While wcnt≠0, decrement wcnt each cycle. When wcnt==0, the data phase completes.
    - If a new transfer is accepted in the same cycle, stay in DATA and reload wcnt (or go to ERR1 for an illegal transfer).
    - Otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=ERROR. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR. Behaves like DATA completion with respect to accepting the next address phase.
- **Writes.** Memory is updated at the completing edge of DATA using HWDATA under a byte mask:
  - byte: lane HADDR[1:0];
  - half: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
- **Reads.** HRDATA = mem[addr_q], full word with all lanes driven, during DATA when write_q=0. Otherwise HRDATA=0.
- **Address decode.** Word index = (HADDR − BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- **Reset.** Asserting HRESETn low at any time forces IDLE, wcnt=0, HREADYOUT=1, HRESP=00 and HRDATA=0. A write in progress is discarded. Memory contents are not reset.

## Timing
- Accept at edge N. Data phase spans N+1 … N+1+WAIT_STATES. The transfer completes at the edge ending cycle N+1+WAIT_STATES.
- With WAIT_STATES=0 the slave sustains one transfer per cycle.
- Write followed immediately by a read of the same word: the read data phase returns the new data, because the write commits at the edge that starts the read's data phase.
- Error response is always exactly two cycles (ERR1, ERR2), independent of WAIT_STATES.
- While HREADYOUT=0, new address phases are not sampled, since HREADY is low.

## Configuration
- **AHB_SRAM_ERR_EN defined.** An accepted transfer is illegal, and takes the two-cycle ERROR response with no memory access, if any of the following holds:
  - address is outside [BASE_ADDR, BASE_ADDR+DEPTH*4);
  - HSIZE > 010;
  - the access is misaligned: half with HADDR[0]=1, or word with HADDR[1:0]≠00.
- **Not defined.** No transfer is illegal; HRESP is constantly 00.
  - Out-of-range addresses wrap modulo DEPTH.
  - HSIZE > 010 is treated as word.
  - Misaligned accesses use the lane mask computed from the aligned-down address.
  - The ERR1 and ERR2 states are not compiled.

## Test plan
- Reset: assert HRESETn low mid-DATA → HREADYOUT=1, HRESP=00, HRDATA=0 immediately. A following read of the interrupted word shows the old value.
- WAIT_STATES=2: word write 32'hDEAD_BEEF to 0x10, then read of 0x10 → exactly 2 HREADYOUT-low cycles per data phase, and the read returns 32'hDEAD_BEEF.
- Byte lanes: write word 0x11223344 to 0x20, byte write 0xAA to 0x22, half write 0xBBCC to 0x20 → read of 0x20 returns 32'h11AA_BBCC.
- WAIT_STATES=0 pipelined burst: NONSEQ/SEQ writes to 0x0, 0x4, 0x8, then reads back → no wait cycles; data returned in order; a BUSY beat inserted between beats gets an OKAY with no access.
- With AHB_SRAM_ERR_EN, word read at 0x2 → HRESP=01 with HREADYOUT=0 then 1, and no memory change. An IDLE issued in ERR2 returns the slave to IDLE/OKAY.
- Without AHB_SRAM_ERR_EN, DEPTH=1024: write 32'h5 to BASE_ADDR+0x1000 → reads back at BASE_ADDR+0x0 with HRESP=00.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/interconnect and ahb_sram_slave.
// Signals:
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
//   HREADY                      - driven by the master side
//   HREADYOUT, HRESP, HRDATA    - driven by the slave side
// HREADY is the bus-level ready; in a single-slave system it is simply
// HREADYOUT looped back by the interconnect.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    input  HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    output HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-organised SRAM with little-endian byte
// lanes and a fixed number of wait states per OKAY data phase.
// Ports:
//   HCLK     - bus clock, rising-edge
//   HRESETn  - asynchronous active-low reset
//   ahb_s    - ahb_sram_slave_if.slave bus bundle
// Parameters: DEPTH (words, power of two >= 4), WAIT_STATES (0..15),
//   BASE_ADDR (byte address of word 0, DEPTH*4 aligned).
// Build option: define AHB_SRAM_ERR_EN to answer out-of-range, oversized
//   and misaligned transfers with a two-cycle ERROR response. Without it,
//   addresses wrap, oversize is treated as word and HRESP stays OKAY.
//
// state | meaning
// IDLE  | no data phase pending, ready and OKAY
// DATA  | data phase of an accepted transfer, counting down wait states
// ERR1  | first ERROR cycle, not ready
// ERR2  | second ERROR cycle, ready; next address phase may be accepted
module ahb_sram_slave #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic            HCLK,
  input logic            HRESETn,
  ahb_sram_slave_if.slave ahb_s
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1
`ifdef AHB_SRAM_ERR_EN
    , ERR1 = 2'd2,
    ERR2 = 2'd3
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [AW-1:0] addr_q;
  logic [1:0]    lane_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic          take;
  logic          accept;
  logic          commit;
  logic [3:0]    mask;
  logic [31:0]   offset;
  logic [31:0]   mem [DEPTH];

  assign offset = ahb_s.HADDR - BASE_ADDR;
  assign accept = ahb_s.HSEL & ahb_s.HREADY & ahb_s.HTRANS[1];

`ifdef AHB_SRAM_ERR_EN
  logic illegal;
  // The unsigned offset wraps for addresses below BASE_ADDR, so one compare
  // covers both ends of the window.
  assign illegal = (offset >= 32'(DEPTH * 4))
                 || (ahb_s.HSIZE > 3'b010)
                 || (ahb_s.HSIZE == 3'b001 && ahb_s.HADDR[0])
                 || (ahb_s.HSIZE == 3'b010 && ahb_s.HADDR[1:0] != 2'b00);
  logic unused_ok;
  assign unused_ok = &{1'b0, ahb_s.HBURST, ahb_s.HPROT, ahb_s.HMASTLOCK,
                       ahb_s.HTRANS[0], offset[1:0]};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, ahb_s.HBURST, ahb_s.HPROT, ahb_s.HMASTLOCK,
                       ahb_s.HTRANS[0], offset[1:0], offset[31:AW+2]};
`endif

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    take    = 1'b0;
    case (state_q)
      DATA: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else if (accept) begin
          take    = 1'b1;
          state_d = DATA;
          wcnt_d  = 4'(WAIT_STATES);
        end else begin
          state_d = IDLE;
        end
      end
`ifdef AHB_SRAM_ERR_EN
      ERR1: state_d = ERR2;
      ERR2: begin
        if (accept) begin
          take    = 1'b1;
          state_d = DATA;
          wcnt_d  = 4'(WAIT_STATES);
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        if (accept) begin
          take    = 1'b1;
          state_d = DATA;
          wcnt_d  = 4'(WAIT_STATES);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
`ifdef AHB_SRAM_ERR_EN
    // An illegal transfer is still taken (it owns the next data phase) but
    // is diverted to the error sequence and never touches memory.
    if (take && illegal) begin
      state_d = ERR1;
      wcnt_d  = 4'd0;
    end
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      lane_q  <= 2'b00;
      size_q  <= 3'b000;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (take) begin
        addr_q  <= offset[AW+1:2];
        lane_q  <= ahb_s.HADDR[1:0];
        size_q  <= ahb_s.HSIZE;
        write_q <= ahb_s.HWRITE;
      end
    end
  end

  // Half-word lanes come from lane_q[1] only, which also aligns a
  // misaligned half down when errors are not checked.
  always_comb begin
    mask = 4'b1111;
    case (size_q)
      3'b000:  mask = 4'b0001 << lane_q;
      3'b001:  mask = lane_q[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  assign commit = (state_q == DATA) && (wcnt_q == 4'd0) && write_q;

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (mask[b]) mem[addr_q][8*b +: 8] <= ahb_s.HWDATA[8*b +: 8];
      end
    end
  end

  assign ahb_s.HRDATA = (state_q == DATA && !write_q) ? mem[addr_q] : 32'h0;

`ifdef AHB_SRAM_ERR_EN
  assign ahb_s.HREADYOUT = (state_q == DATA) ? (wcnt_q == 4'd0) : (state_q != ERR1);
  assign ahb_s.HRESP     = (state_q == ERR1 || state_q == ERR2) ? 2'b01 : 2'b00;
`else
  assign ahb_s.HREADYOUT = (state_q == DATA) ? (wcnt_q == 4'd0) : 1'b1;
  assign ahb_s.HRESP     = 2'b00;
`endif
endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
  localparam logic [31:0] B0 = 32'h4000_0000;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   checks = 0;
  int   errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus2 ();
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(B0)) u_ws0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb_s(bus0.slave));
  ahb_sram_slave #(.DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u_ws2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb_s(bus2.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input bit w2, input logic sel, input logic [1:0] trans,
                          input logic wr, input logic [2:0] size, input logic [31:0] addr);
    if (w2) begin
      bus2.HSEL = sel; bus2.HTRANS = trans; bus2.HWRITE = wr;
      bus2.HSIZE = size; bus2.HADDR = addr;
    end else begin
      bus0.HSEL = sel; bus0.HTRANS = trans; bus0.HWRITE = wr;
      bus0.HSIZE = size; bus0.HADDR = addr;
    end
  endtask

  task automatic set_wdata(input bit w2, input logic [31:0] d);
    if (w2) bus2.HWDATA = d; else bus0.HWDATA = d;
  endtask

  function automatic logic get_ready(input bit w2);
    return w2 ? bus2.HREADYOUT : bus0.HREADYOUT;
  endfunction
  function automatic logic [1:0] get_resp(input bit w2);
    return w2 ? bus2.HRESP : bus0.HRESP;
  endfunction
  function automatic logic [31:0] get_rdata(input bit w2);
    return w2 ? bus2.HRDATA : bus0.HRDATA;
  endfunction

  // Single transfer: address phase, then hold IDLE while the data phase runs.
  task automatic xfer(input bit w2, input logic wr, input logic [2:0] size,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits,
                      output logic [1:0] resp_first, output logic [1:0] resp_last);
    @(negedge HCLK);
    set_addr(w2, 1'b1, 2'b10, wr, size, addr);
    @(negedge HCLK);
    set_addr(w2, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    set_wdata(w2, wd);
    resp_first = get_resp(w2);
    waits = 0;
    while (get_ready(w2) !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge HCLK);
    end
    if (waits >= 20) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout addr=%h observed=HREADYOUT stuck low expected=high", addr);
    end
    rd = get_rdata(w2);
    resp_last = get_resp(w2);
  endtask

  logic [31:0] rd;
  int          waits;
  logic [1:0]  r1, r2;

  initial begin
    HRESETn = 1'b0;
    set_addr(1'b0, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    set_addr(1'b1, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    set_wdata(1'b0, 32'h0);
    set_wdata(1'b1, 32'h0);
    bus0.HBURST = 3'b000; bus0.HPROT = 4'h3; bus0.HMASTLOCK = 1'b0;
    bus2.HBURST = 3'b000; bus2.HPROT = 4'h3; bus2.HMASTLOCK = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("reset_ready", {31'h0, bus2.HREADYOUT}, 32'h1);
    chk("reset_resp", {30'h0, bus2.HRESP}, 32'h0);
    chk("reset_rdata", bus2.HRDATA, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Two wait states per data phase
    xfer(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, waits, r1, r2);
    chk("ws2_write_waits", 32'(waits), 32'd2);
    chk("ws2_write_resp", {30'h0, r2}, 32'h0);
    xfer(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, waits, r1, r2);
    chk("ws2_read_waits", 32'(waits), 32'd2);
    chk("ws2_read_data", rd, 32'hDEAD_BEEF);

    // Byte lanes, junk in the unselected lanes must be masked off
    xfer(1'b1, 1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, waits, r1, r2);
    xfer(1'b1, 1'b1, 3'b000, 32'h22, 32'h55AA_5555, rd, waits, r1, r2);
    xfer(1'b1, 1'b1, 3'b001, 32'h20, 32'h7777_BBCC, rd, waits, r1, r2);
    xfer(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rd, waits, r1, r2);
    chk("byte_lanes", rd, 32'h11AA_BBCC);

    // Zero-wait pipelined burst with BUSY beats
    @(negedge HCLK);
    set_addr(1'b0, 1'b1, 2'b10, 1'b1, 3'b010, B0 + 32'h0);
    @(negedge HCLK);
    chk("burst_w0_ready", {31'h0, bus0.HREADYOUT}, 32'h1);
    set_addr(1'b0, 1'b1, 2'b11, 1'b1, 3'b010, B0 + 32'h4);
    set_wdata(1'b0, 32'hA1A1_0001);
    @(negedge HCLK);
    chk("burst_w1_ready", {31'h0, bus0.HREADYOUT}, 32'h1);
    set_addr(1'b0, 1'b1, 2'b01, 1'b1, 3'b010, B0 + 32'h8);
    set_wdata(1'b0, 32'hB2B2_0002);
    @(negedge HCLK);
    chk("burst_busy_ready", {31'h0, bus0.HREADYOUT}, 32'h1);
    chk("burst_busy_resp", {30'h0, bus0.HRESP}, 32'h0);
    set_addr(1'b0, 1'b1, 2'b11, 1'b1, 3'b010, B0 + 32'h8);
    set_wdata(1'b0, 32'hFFFF_FFFF);
    @(negedge HCLK);
    set_addr(1'b0, 1'b1, 2'b10, 1'b0, 3'b010, B0 + 32'h0);
    set_wdata(1'b0, 32'hC3C3_0003);
    @(negedge HCLK);
    chk("burst_r0_data", bus0.HRDATA, 32'hA1A1_0001);
    chk("burst_r0_ready", {31'h0, bus0.HREADYOUT}, 32'h1);
    set_addr(1'b0, 1'b1, 2'b11, 1'b0, 3'b010, B0 + 32'h4);
    @(negedge HCLK);
    chk("burst_r1_data", bus0.HRDATA, 32'hB2B2_0002);
    set_addr(1'b0, 1'b1, 2'b01, 1'b0, 3'b010, B0 + 32'h8);
    @(negedge HCLK);
    chk("burst_busy_rdata", bus0.HRDATA, 32'h0);
    chk("burst_busy2_ready", {31'h0, bus0.HREADYOUT}, 32'h1);
    set_addr(1'b0, 1'b1, 2'b11, 1'b0, 3'b010, B0 + 32'h8);
    @(negedge HCLK);
    chk("burst_r2_data", bus0.HRDATA, 32'hC3C3_0003);
    set_addr(1'b0, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);

    // Reset in the middle of a write data phase
    xfer(1'b1, 1'b1, 3'b010, 32'h30, 32'h1234_5678, rd, waits, r1, r2);
    @(negedge HCLK);
    set_addr(1'b1, 1'b1, 2'b10, 1'b1, 3'b010, 32'h30);
    @(negedge HCLK);
    set_addr(1'b1, 1'b0, 2'b00, 1'b0, 3'b010, 32'h0);
    set_wdata(1'b1, 32'hCAFE_0001);
    chk("rst_pre_ready", {31'h0, bus2.HREADYOUT}, 32'h0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid_ready", {31'h0, bus2.HREADYOUT}, 32'h1);
    chk("rst_mid_resp", {30'h0, bus2.HRESP}, 32'h0);
    chk("rst_mid_rdata", bus2.HRDATA, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    xfer(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rd, waits, r1, r2);
    chk("rst_discard_write", rd, 32'h1234_5678);

`ifdef AHB_SRAM_ERR_EN
    xfer(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, rd, waits, r1, r2);
    chk("err_resp_first", {30'h0, r1}, 32'h1);
    chk("err_low_cycles", 32'(waits), 32'd1);
    chk("err_resp_last", {30'h0, r2}, 32'h1);
    @(negedge HCLK);
    chk("err_idle_resp", {30'h0, bus2.HRESP}, 32'h0);
    chk("err_idle_ready", {31'h0, bus2.HREADYOUT}, 32'h1);
    xfer(1'b1, 1'b1, 3'b010, 32'h12, 32'h0000_0000, rd, waits, r1, r2);
    chk("err_write_resp", {30'h0, r2}, 32'h1);
    xfer(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rd, waits, r1, r2);
    chk("err_no_mem_change", rd, 32'hDEAD_BEEF);
`else
    xfer(1'b0, 1'b1, 3'b010, B0 + 32'h1000, 32'h0000_0005, rd, waits, r1, r2);
    chk("wrap_write_resp", {30'h0, r2}, 32'h0);
    xfer(1'b0, 1'b0, 3'b010, B0 + 32'h0, 32'h0, rd, waits, r1, r2);
    chk("wrap_read_data", rd, 32'h0000_0005);
    chk("wrap_read_resp", {30'h0, r2}, 32'h0);
`endif

    repeat (2) @(negedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
